// File: rtl/exposure_sequencer.sv
// rtl/exposure_sequencer.sv - multi-channel relay exposure timer with shared ARM/FIRE/ABORT control
// Optional cumulative ON-time watchdog: define EXPOSURE_WATCHDOG_EN.
module exposure_sequencer #(
  parameter int CLK_HZ   = 16_000_000,
  parameter int TICK_HZ  = 1000,
  parameter int CHANNELS = 2,
  parameter int TIME_W   = 14
`ifdef EXPOSURE_WATCHDOG_EN
  , parameter int WDOG_MAX = 20000
`endif
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      arm,
  input  logic                      fire,
  input  logic                      abort,
  input  logic                      cfg_we,
  input  logic [$clog2(CHANNELS):0] cfg_ch,
  input  logic [1:0]                cfg_sel,
  input  logic [TIME_W-1:0]         cfg_data,
  output logic [CHANNELS-1:0]       ch_out,
  output logic [1:0]                state,
  output logic                      done,
  output logic                      cfg_err,
  output logic [TIME_W-1:0]         rep_cnt0
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PRE_W    = $clog2(TICK_DIV);
  localparam int CH_W     = $clog2(CHANNELS) + 1;
  localparam logic [PRE_W-1:0]  TICK_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0]  PRE_ONE   = PRE_W'(1);
  localparam logic [CH_W-1:0]   CH_LIM    = CH_W'(CHANNELS);
  localparam logic [TIME_W-1:0] TIME_MAX  = TIME_W'(9999);
  localparam logic [TIME_W-1:0] ONE       = TIME_W'(1);
  localparam logic [TIME_W-1:0] ON_RST    = TIME_W'(3000);
  localparam logic [TIME_W-1:0] OFF_RST   = TIME_W'(100);
`ifdef EXPOSURE_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_MAX + 1);
  localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(WDOG_MAX);
  localparam logic [WDOG_W-1:0] WDOG_ONE = WDOG_W'(1);
`endif

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_FIRE = 2'd2, S_FAULT = 2'd3} state_t;

  typedef struct packed {
    logic              off;
    logic              done;
    logic              out;
    logic [TIME_W-1:0] rep;
  } rep_start_t;

  state_t              r_state, w_state_nxt;
  logic [PRE_W-1:0]    r_presc, w_presc_nxt;
  logic [TIME_W-1:0]   r_on      [CHANNELS];
  logic [TIME_W-1:0]   r_off     [CHANNELS];
  logic [TIME_W-1:0]   r_reps    [CHANNELS];
  logic [TIME_W-1:0]   r_cnt     [CHANNELS];
  logic [TIME_W-1:0]   r_rep     [CHANNELS];
  logic [TIME_W-1:0]   w_cnt_nxt [CHANNELS];
  logic [TIME_W-1:0]   w_rep_nxt [CHANNELS];
  logic [CHANNELS-1:0] r_phase, w_phase_nxt;
  logic [CHANNELS-1:0] r_ch_done, w_ch_done_nxt;
  logic [CHANNELS-1:0] r_ch_out, w_ch_out_nxt;
  logic                r_fire_q, r_done, w_done_nxt, r_cfg_err;
  logic                w_tick, w_fire_rise, w_cfg_ok, w_cfg_err_nxt;
  logic [TIME_W-1:0]   w_cfg_val;
`ifdef EXPOSURE_WATCHDOG_EN
  logic [WDOG_W-1:0]   r_wdog     [CHANNELS];
  logic [WDOG_W-1:0]   w_wdog_nxt [CHANNELS];
  logic                w_wdog_trip;
`endif

  // Begin a repetition at completed count rep_in; a zero on_time counts the rep without a pulse.
  function automatic rep_start_t start_rep(input logic [TIME_W-1:0] on_t,
                                           input logic [TIME_W-1:0] reps_t,
                                           input logic [TIME_W-1:0] rep_in);
    rep_start_t s;
    s = '0;
    s.rep = rep_in;
    if (rep_in == reps_t) begin
      s.done = 1'b1;
    end else if (on_t != '0) begin
      s.out = 1'b1;
    end else begin
      s.rep = rep_in + ONE;
      if (s.rep == reps_t) s.done = 1'b1;
      else                 s.off  = 1'b1;
    end
    return s;
  endfunction

  assign w_tick        = (r_presc == TICK_LAST);
  assign w_fire_rise   = fire && !r_fire_q;
  assign w_cfg_ok      = cfg_we && (r_state == S_IDLE) && (cfg_ch < CH_LIM);
  assign w_cfg_err_nxt = cfg_we && ((r_state != S_IDLE) || (cfg_ch >= CH_LIM));
  assign w_cfg_val     = (cfg_data > TIME_MAX) ? TIME_MAX : cfg_data;

  always_comb begin
    rep_start_t        v_rs;
    logic [TIME_W-1:0] v_rep;
`ifdef EXPOSURE_WATCHDOG_EN
    logic [WDOG_W-1:0] v_wd;
`endif
    v_rs          = '0;
    v_rep         = '0;
    w_state_nxt   = r_state;
    w_presc_nxt   = r_presc;
    w_cnt_nxt     = r_cnt;
    w_rep_nxt     = r_rep;
    w_phase_nxt   = r_phase;
    w_ch_done_nxt = r_ch_done;
    w_ch_out_nxt  = r_ch_out;
    w_done_nxt    = 1'b0;
`ifdef EXPOSURE_WATCHDOG_EN
    v_wd          = '0;
    w_wdog_nxt    = r_wdog;
    w_wdog_trip   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (arm && !abort) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (abort || !arm) begin
          w_state_nxt  = S_IDLE;
          w_ch_out_nxt = '0;
        end else if (w_fire_rise) begin
          w_state_nxt = S_FIRE;
          w_presc_nxt = '0;
          for (int i = 0; i < CHANNELS; i++) begin
            v_rs             = start_rep(r_on[i], r_reps[i], '0);
            w_cnt_nxt[i]     = '0;
            w_rep_nxt[i]     = v_rs.rep;
            w_phase_nxt[i]   = v_rs.off;
            w_ch_done_nxt[i] = v_rs.done;
            w_ch_out_nxt[i]  = v_rs.out;
`ifdef EXPOSURE_WATCHDOG_EN
            w_wdog_nxt[i]    = '0;
`endif
          end
        end
      end
      S_FIRE: begin
        if (abort || !arm) begin
          w_state_nxt  = S_IDLE;
          w_ch_out_nxt = '0;
        end else begin
          w_presc_nxt = w_tick ? '0 : r_presc + PRE_ONE;
          for (int i = 0; i < CHANNELS; i++) begin
            if (w_tick && !r_ch_done[i]) begin
              if (!r_phase[i]) begin
`ifdef EXPOSURE_WATCHDOG_EN
                v_wd          = r_wdog[i] + WDOG_ONE;
                w_wdog_nxt[i] = v_wd;
                if (v_wd == WDOG_LIM) w_wdog_trip = 1'b1;
`endif
                if (r_cnt[i] == r_on[i] - ONE) begin
                  v_rep        = r_rep[i] + ONE;
                  w_cnt_nxt[i] = '0;
                  w_rep_nxt[i] = v_rep;
                  if (v_rep == r_reps[i]) begin
                    w_ch_done_nxt[i] = 1'b1;
                    w_ch_out_nxt[i]  = 1'b0;
                  end else if (r_off[i] != '0) begin
                    w_phase_nxt[i]  = 1'b1;
                    w_ch_out_nxt[i] = 1'b0;
                  end
                end else begin
                  w_cnt_nxt[i] = r_cnt[i] + ONE;
                end
              end else if ((r_off[i] == '0) || (r_cnt[i] == r_off[i] - ONE)) begin
                v_rs             = start_rep(r_on[i], r_reps[i], r_rep[i]);
                w_cnt_nxt[i]     = '0;
                w_rep_nxt[i]     = v_rs.rep;
                w_phase_nxt[i]   = v_rs.off;
                w_ch_done_nxt[i] = v_rs.done;
                w_ch_out_nxt[i]  = v_rs.out;
              end else begin
                w_cnt_nxt[i] = r_cnt[i] + ONE;
              end
            end
          end
          if (&w_ch_done_nxt) begin
            w_done_nxt   = 1'b1;
            w_state_nxt  = S_ARMED;
            w_ch_out_nxt = '0;
          end
`ifdef EXPOSURE_WATCHDOG_EN
          if (w_wdog_trip) begin
            w_done_nxt   = 1'b0;
            w_state_nxt  = S_FAULT;
            w_ch_out_nxt = '0;
          end
`endif
        end
      end
      default: begin
        w_ch_out_nxt = '0;
        if (abort) w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_presc   <= '0;
      r_phase   <= '0;
      r_ch_done <= '0;
      r_ch_out  <= '0;
      r_fire_q  <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_cnt[i] <= '0;
        r_rep[i] <= '0;
`ifdef EXPOSURE_WATCHDOG_EN
        r_wdog[i] <= '0;
`endif
      end
    end else begin
      r_state   <= w_state_nxt;
      r_presc   <= w_presc_nxt;
      r_phase   <= w_phase_nxt;
      r_ch_done <= w_ch_done_nxt;
      r_ch_out  <= w_ch_out_nxt;
      r_fire_q  <= fire;
      r_done    <= w_done_nxt;
      r_cfg_err <= w_cfg_err_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rep     <= w_rep_nxt;
`ifdef EXPOSURE_WATCHDOG_EN
      r_wdog    <= w_wdog_nxt;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_on[i]   <= ON_RST;
        r_off[i]  <= OFF_RST;
        r_reps[i] <= ONE;
      end
    end else if (w_cfg_ok) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (cfg_ch == CH_W'(i)) begin
          case (cfg_sel)
            2'd0:    r_on[i]   <= w_cfg_val;
            2'd1:    r_off[i]  <= w_cfg_val;
            2'd2:    r_reps[i] <= w_cfg_val;
            default: ;
          endcase
        end
      end
    end
  end

  assign ch_out   = r_ch_out;
  assign state    = r_state;
  assign done     = r_done;
  assign cfg_err  = r_cfg_err;
  assign rep_cnt0 = r_rep[0];

endmodule

// File: tb/tb_exposure_sequencer.sv
// tb/tb_exposure_sequencer.sv - directed self-checking bench for exposure_sequencer
// Watchdog scenario runs when EXPOSURE_WATCHDOG_EN is defined.
module tb_exposure_sequencer;

  logic        clk;
  logic        reset_n;
  logic        arm, fire, abort, cfg_we;
  logic [1:0]  cfg_ch;
  logic [1:0]  cfg_sel;
  logic [13:0] cfg_data;
  logic [1:0]  ch_out;
  logic [1:0]  state;
  logic        done, cfg_err;
  logic [13:0] rep_cnt0;

  int n_total = 0;
  int n_bad   = 0;

  logic       hist_ch0  [1:200];
  logic       hist_ch1  [1:200];
  logic       hist_done [1:200];
  logic [1:0] hist_st   [1:200];

  exposure_sequencer #(
    .CLK_HZ(1000), .TICK_HZ(100), .CHANNELS(2), .TIME_W(14)
`ifdef EXPOSURE_WATCHDOG_EN
    , .WDOG_MAX(5)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n), .arm(arm), .fire(fire), .abort(abort),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .ch_out(ch_out), .state(state), .done(done), .cfg_err(cfg_err), .rep_cnt0(rep_cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [1:0] sel,
                           input logic [13:0] data, output logic err);
    cfg_ch = ch; cfg_sel = sel; cfg_data = data; cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
    err = cfg_err;
  endtask

  // Raise fire at a negedge, then record outputs at the following n negedges.
  task automatic run_fire(input int n);
    fire = 1'b1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      fire = 1'b0;
      hist_ch0[i]  = ch_out[0];
      hist_ch1[i]  = ch_out[1];
      hist_done[i] = done;
      hist_st[i]   = state;
    end
  endtask

  function automatic int ones0(input int n);
    int c = 0;
    for (int i = 1; i <= n; i++) c += int'(hist_ch0[i]);
    return c;
  endfunction

  function automatic int ones1(input int n);
    int c = 0;
    for (int i = 1; i <= n; i++) c += int'(hist_ch1[i]);
    return c;
  endfunction

  function automatic int done_cnt(input int n);
    int c = 0;
    for (int i = 1; i <= n; i++) c += int'(hist_done[i]);
    return c;
  endfunction

  function automatic int done_at(input int n);
    for (int i = 1; i <= n; i++) if (hist_done[i]) return i;
    return 0;
  endfunction

  initial begin
    logic err;
    int   highs;
    reset_n = 1'b0; arm = 1'b0; fire = 1'b0; abort = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
    step(3);
    check("rst_state", state, 0);
    check("rst_ch_out", ch_out, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_rep_cnt0", rep_cnt0, 0);
    reset_n = 1'b1;
    step(1);
    check("post_rst_state", state, 0);

    // Two reps of 3 on / 2 off on ch0, ch1 disabled
    cfg_write(2'd0, 2'd0, 14'd3, err);
    check("cfg_idle_ok", err, 0);
    cfg_write(2'd0, 2'd1, 14'd2, err);
    cfg_write(2'd0, 2'd2, 14'd2, err);
    cfg_write(2'd1, 2'd2, 14'd0, err);
    arm = 1'b1;
    step(1);
    check("armed", state, 1);
    run_fire(100);
    check("t1_first_on", hist_ch0[1], 1);
    check("t1_on_end", hist_ch0[30], 1);
    check("t1_off_start", hist_ch0[31], 0);
    check("t1_off_end", hist_ch0[50], 0);
    check("t1_rep2_start", hist_ch0[51], 1);
    check("t1_rep2_end", hist_ch0[80], 1);
    check("t1_final_low", hist_ch0[81], 0);
    check("t1_high_cycles", ones0(100), 60);
    check("t1_done_at", done_at(100), 81);
    check("t1_done_pulses", done_cnt(100), 1);
    check("t1_state_after", hist_st[81], 1);
    check("t1_fire_state", hist_st[1], 2);
    check("t1_ch1_quiet", ones1(100), 0);
    check("t1_rep_cnt0", rep_cnt0, 2);

    // reps=0 on ch1, single 1-tick pulse on ch0
    arm = 1'b0;
    step(1);
    cfg_write(2'd0, 2'd0, 14'd1, err);
    cfg_write(2'd0, 2'd2, 14'd1, err);
    arm = 1'b1;
    step(1);
    run_fire(30);
    check("t2_on_last", hist_ch0[10], 1);
    check("t2_off", hist_ch0[11], 0);
    check("t2_high_cycles", ones0(30), 10);
    check("t2_done_at", done_at(30), 11);
    check("t2_state_armed", hist_st[11], 1);
    check("t2_ch1_quiet", ones1(30), 0);
    check("t2_rep_cnt0", rep_cnt0, 1);

    // Abort in the middle of an ON phase
    arm = 1'b0;
    step(1);
    cfg_write(2'd0, 2'd0, 14'd3, err);
    arm = 1'b1;
    step(1);
    run_fire(15);
    check("t3_on_before_abort", hist_ch0[15], 1);
    abort = 1'b1;
    step(1);
    check("t3_abort_out", ch_out, 0);
    check("t3_abort_state", state, 0);
    abort = 1'b0; arm = 1'b0;
    step(2);
    run_fire(12);
    check("t3_fire_unarmed_out", ones0(12) + ones1(12), 0);
    check("t3_fire_unarmed_state", hist_st[12], 0);

    // Config write while armed is rejected and old on_time kept
    arm = 1'b1;
    step(1);
    check("t4_armed", state, 1);
    cfg_write(2'd0, 2'd0, 14'd50, err);
    check("t4_cfg_err_pulse", err, 1);
    step(1);
    check("t4_cfg_err_clear", cfg_err, 0);
    run_fire(40);
    check("t4_old_on_last", hist_ch0[30], 1);
    check("t4_old_on_off", hist_ch0[31], 0);
    check("t4_high_cycles", ones0(40), 30);
    check("t4_done_at", done_at(40), 31);
    arm = 1'b0;
    step(1);
    cfg_write(2'd2, 2'd0, 14'd5, err);
    check("t4_bad_ch_err", err, 1);
    cfg_write(2'd0, 2'd3, 14'd5, err);
    check("t4_reserved_sel_ok", err, 0);

    // Fire held through arming must not start a run
    fire = 1'b1;
    step(3);
    arm = 1'b1;
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      highs += int'(ch_out[0]) + int'(ch_out[1]);
    end
    check("t5_held_no_out", highs, 0);
    check("t5_held_state", state, 1);
    fire = 1'b0;
    step(1);
    run_fire(1);
    check("t5_repress_out", hist_ch0[1], 1);
    check("t5_repress_state", hist_st[1], 2);
    abort = 1'b1;
    step(1);
    check("t5_abort_state", state, 0);
    abort = 1'b0; arm = 1'b0;
    step(1);

`ifdef EXPOSURE_WATCHDOG_EN
    cfg_write(2'd0, 2'd0, 14'd9, err);
    arm = 1'b1;
    step(1);
    run_fire(55);
    check("t6_on_last", hist_ch0[50], 1);
    check("t6_trip_out", hist_ch0[51], 0);
    check("t6_fault_state", hist_st[51], 3);
    check("t6_no_done", done_cnt(55), 0);
    arm = 1'b0;
    step(1);
    check("t6_fault_holds", state, 3);
    abort = 1'b1;
    step(1);
    check("t6_abort_idle", state, 0);
    abort = 1'b0;
    step(1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
